// File: rtl/spi_pwm_config.sv
`default_nettype none
// ============================================================================
// Module   : spi_pwm_config
// Purpose  : SPI mode-0 write-only configuration port for pwm_peripheral.
//            Receives 16-bit frames {R/W, addr[6:0], data[7:0]} MSB first and
//            commits write frames to one of five 8-bit registers.
// Ports    : clk, rst_n          - system clock, async active-low reset
//            sclk, copi, ncs     - SPI pins (asynchronous to clk)
//            cipo                - SPI readback data (0 unless SPI_READBACK_EN)
//            en_reg_out_7_0 .. pwm_duty_cycle - configuration registers
//            wr_strobe           - one-cycle pulse on each register commit
//            frame_err           - one-cycle pulse on each discarded frame
// Macro    : SPI_READBACK_EN - when defined, read frames shift the addressed
//            register out on cipo; otherwise cipo is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pwm_config #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [6:0] MAX_ADDR    = 7'h04
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclk,
   input  logic       copi,
   input  logic       ncs,
   output logic       cipo,
   output logic [7:0] en_reg_out_7_0,
   output logic [7:0] en_reg_out_15_8,
   output logic [7:0] en_reg_pwm_7_0,
   output logic [7:0] en_reg_pwm_15_8,
   output logic [7:0] pwm_duty_cycle,
   output logic       wr_strobe,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } state_t;

   localparam logic [4:0] c_FRAME_BITS = 5'd16;
   localparam logic [4:0] c_ADDR_BITS  = 5'd8;

   // ------------------------------------------------------------------
   // Input synchronizers plus one delay flop for edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_copi_sync;
   logic [SYNC_STAGES-1:0] r_ncs_sync;
   logic                   r_sclk_dly;
   logic                   r_ncs_dly;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sclk_sync <= '0;
         r_copi_sync <= '0;
         r_ncs_sync  <= '1;
         r_sclk_dly  <= 1'b0;
         r_ncs_dly   <= 1'b1;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
         r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
         r_sclk_dly  <= r_sclk_sync[SYNC_STAGES-1];
         r_ncs_dly   <= r_ncs_sync[SYNC_STAGES-1];
      end
   end

   logic w_sclk_s, w_copi_s, w_ncs_s;
   logic w_sclk_rise, w_ncs_fall, w_ncs_rise;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
   assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_dly;
   // ncs delay flop resets high, so ncs held low through reset release
   // still produces a falling edge and starts a frame.
   assign w_ncs_fall  = ~w_ncs_s & r_ncs_dly;
   assign w_ncs_rise  = w_ncs_s & ~r_ncs_dly;

   // ------------------------------------------------------------------
   // Frame capture and commit
   // ------------------------------------------------------------------
   state_t      r_state;
   logic [15:0] r_shift;
   logic [4:0]  r_count;
   logic [7:0]  r_en_out_lo, r_en_out_hi, r_en_pwm_lo, r_en_pwm_hi, r_duty;
   logic        r_wr_strobe, r_frame_err;

   logic       w_rw, w_full, w_addr_ok;
   logic [6:0] w_addr;
   logic [7:0] w_data;

   assign w_rw      = r_shift[15];
   assign w_addr    = r_shift[14:8];
   assign w_data    = r_shift[7:0];
   assign w_full    = (r_count == c_FRAME_BITS);
   assign w_addr_ok = (w_addr <= MAX_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_count     <= '0;
         r_en_out_lo <= '0;
         r_en_out_hi <= '0;
         r_en_pwm_lo <= '0;
         r_en_pwm_hi <= '0;
         r_duty      <= '0;
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
      end else begin
         r_wr_strobe <= 1'b0;
         r_frame_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_ncs_fall) begin
                  r_state <= ST_SHIFT;
                  r_count <= '0;
                  r_shift <= '0;
               end
            end
            ST_SHIFT: begin
               // Counter saturates at 16; surplus bits leave the frame intact.
               if (w_sclk_rise && !w_full) begin
                  r_shift <= {r_shift[14:0], w_copi_s};
                  r_count <= r_count + 5'd1;
               end
               if (w_ncs_rise) begin
                  r_state <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               if (w_full && w_rw && w_addr_ok) begin
                  r_wr_strobe <= 1'b1;
                  case (w_addr)
                     7'h00:   r_en_out_lo <= w_data;
                     7'h01:   r_en_out_hi <= w_data;
                     7'h02:   r_en_pwm_lo <= w_data;
                     7'h03:   r_en_pwm_hi <= w_data;
                     7'h04:   r_duty      <= w_data;
                     default: ;
                  endcase
               end else if (!w_full || !w_addr_ok) begin
                  r_frame_err <= 1'b1;
               end
               // A very short ncs-high gap can show its fall during this
               // cycle; start the next frame directly so it is not lost.
               if (w_ncs_fall) begin
                  r_state <= ST_SHIFT;
                  r_count <= '0;
                  r_shift <= '0;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign en_reg_out_7_0  = r_en_out_lo;
   assign en_reg_out_15_8 = r_en_out_hi;
   assign en_reg_pwm_7_0  = r_en_pwm_lo;
   assign en_reg_pwm_15_8 = r_en_pwm_hi;
   assign pwm_duty_cycle  = r_duty;
   assign wr_strobe       = r_wr_strobe;
   assign frame_err       = r_frame_err;

   // ------------------------------------------------------------------
   // Optional readback shifter
   // ------------------------------------------------------------------
`ifdef SPI_READBACK_EN
   logic       w_sclk_fall;
   logic [7:0] w_rd_data;
   logic [7:0] r_tx;

   assign w_sclk_fall = ~w_sclk_s & r_sclk_dly;

   // After 8 bits the header sits in r_shift[7:0]: R/W at [7], address [6:0].
   always_comb begin
      w_rd_data = 8'h00;
      case (r_shift[6:0])
         7'h00:   w_rd_data = r_en_out_lo;
         7'h01:   w_rd_data = r_en_out_hi;
         7'h02:   w_rd_data = r_en_pwm_lo;
         7'h03:   w_rd_data = r_en_pwm_hi;
         7'h04:   w_rd_data = r_duty;
         default: w_rd_data = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tx <= '0;
      end else if (r_state != ST_SHIFT) begin
         r_tx <= '0;
      end else if (w_sclk_fall) begin
         if (r_count == c_ADDR_BITS) begin
            r_tx <= (!r_shift[7] && (r_shift[6:0] <= MAX_ADDR)) ? w_rd_data : 8'h00;
         end else if (r_count > c_ADDR_BITS) begin
            r_tx <= {r_tx[6:0], 1'b0};
         end
      end
   end

   assign cipo = r_tx[7];
`else
   assign cipo = 1'b0;
`endif

endmodule
`default_nettype wire
